// File: rtl/hamming_pkg.sv
// Sizing and bit-position helpers shared by the Hamming decoder and its syndrome block.
package hamming_pkg;

  function automatic int hamming_n(input int p);
    return (1 << p) - 1;
  endfunction

  function automatic int hamming_k(input int p);
    return (1 << p) - p - 1;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // 1-based codeword position of data bit k; data bits fill non-power-of-two slots in order.
  function automatic int data_pos(input int p, input int k);
    int cnt;
    cnt = 0;
    for (int pos = 1; pos <= hamming_n(p); pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == k) return pos;
        cnt++;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome: bit j is the parity of every received position whose 1-based index has bit j set.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int P = 3
) (
  input  logic [hamming_n(P)-1:0] rx_msg,
  output logic [P-1:0]            syndrome
);

  localparam int N = hamming_n(P);

  always_comb begin
    syndrome = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < P; j++) begin
        if ((((i + 1) >> j) & 1) == 1) syndrome[j] = syndrome[j] ^ rx_msg[i];
      end
    end
  end

endmodule

// File: rtl/hamming74_decoder.sv
// Single-error-correcting Hamming decoder, one word per cycle, 1-cycle registered latency, no backpressure.
// Define HAMMING_ERR_STATUS_EN to expose the registered syndrome and a corrected flag.
module hamming74_decoder
  import hamming_pkg::*;
#(
  parameter int P = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [hamming_n(P)-1:0] rx_msg,
`ifdef HAMMING_ERR_STATUS_EN
  output logic [P-1:0]            syndrome,
  output logic                    corrected,
`endif
  output logic                    out_valid,
  output logic [hamming_k(P)-1:0] ec_msg
);

  localparam int N = hamming_n(P);
  localparam int K = hamming_k(P);

  logic [P-1:0] syn_c;
  logic [N-1:0] fixed_c;
  logic [K-1:0] data_c;

  logic [K-1:0] ec_msg_q, ec_msg_d;
  logic         out_valid_q, out_valid_d;

  hamming_syndrome #(.P(P)) u_syndrome (
    .rx_msg   (rx_msg),
    .syndrome (syn_c)
  );

  // A nonzero syndrome names the 1-based position to invert; zero matches no position.
  always_comb begin
    fixed_c = rx_msg;
    for (int i = 0; i < N; i++) begin
      if (syn_c == P'(i + 1)) fixed_c[i] = ~rx_msg[i];
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_extract
    assign data_c[k] = fixed_c[data_pos(P, k) - 1];
  end

  always_comb begin
    ec_msg_d    = ec_msg_q;
    out_valid_d = in_valid;
    if (in_valid) ec_msg_d = data_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ec_msg_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ec_msg_q    <= ec_msg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ec_msg    = ec_msg_q;
  assign out_valid = out_valid_q;

`ifdef HAMMING_ERR_STATUS_EN
  logic [P-1:0] syndrome_q, syndrome_d;
  logic         corrected_q, corrected_d;

  always_comb begin
    syndrome_d  = syndrome_q;
    corrected_d = corrected_q;
    if (in_valid) begin
      syndrome_d  = syn_c;
      corrected_d = (syn_c != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syndrome_q  <= '0;
      corrected_q <= 1'b0;
    end else begin
      syndrome_q  <= syndrome_d;
      corrected_q <= corrected_d;
    end
  end

  assign syndrome  = syndrome_q;
  assign corrected = corrected_q;
`endif

endmodule

// File: tb/tb_hamming74_decoder.sv
// Directed bench for the P=3 Hamming decoder: reset, known vectors, back-to-back, idle hold, single-bit sweep.
module tb_hamming74_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] rx_msg;
  logic       out_valid;
  logic [3:0] ec_msg;
`ifdef HAMMING_ERR_STATUS_EN
  logic [2:0] syndrome;
  logic       corrected;
`endif

  int n_checks;
  int n_fails;

  hamming74_decoder #(.P(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .rx_msg    (rx_msg),
`ifdef HAMMING_ERR_STATUS_EN
    .syndrome  (syndrome),
    .corrected (corrected),
`endif
    .out_valid (out_valid),
    .ec_msg    (ec_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one word at the falling edge, then check it one rising edge later.
  task automatic send_and_check(input string tag, input logic [6:0] word, input logic [3:0] exp_data);
    in_valid = 1'b1;
    rx_msg   = word;
    @(negedge clk);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_dat"}, 32'(ec_msg), 32'(exp_data));
  endtask

  logic [6:0] clean_word;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    rx_msg   = '0;
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_dat", 32'(ec_msg), 32'd0);
    rst_n = 1'b1;

    send_and_check("syn4_parity", 7'b0001000, 4'b0000);
    send_and_check("syn1_parity", 7'b1111110, 4'b1111);
    send_and_check("syn7_pos7",   7'b1011110, 4'b0011);
    send_and_check("syn0_clean",  7'b1010010, 4'b1010);

    // back-to-back words with syndromes 1 and 6
    send_and_check("b2b_first",  7'b1001101, 4'b1001);
    send_and_check("b2b_second", 7'b0010100, 4'b0111);

    in_valid = 1'b0;
    rx_msg   = 7'b1111111;
    @(negedge clk);
    check("idle_vld", 32'(out_valid), 32'd0);
    check("idle_hold", 32'(ec_msg), 32'h7);

    // every single-bit error on a clean codeword must decode back to its data
    clean_word = 7'b1010010;
    for (int i = 0; i < 7; i++) begin
      send_and_check($sformatf("flip_pos%0d", i + 1), clean_word ^ (7'b1 << i), 4'b1010);
    end

    // word accepted, then reset in the following cycle
    send_and_check("pre_rst", 7'b1011110, 4'b0011);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("rst_after_vld", 32'(out_valid), 32'd0);
    check("rst_after_dat", 32'(ec_msg), 32'd0);

    // a word presented while reset is held is discarded
    in_valid = 1'b1;
    rx_msg   = 7'b1111110;
    @(negedge clk);
    check("rst_pending_vld", 32'(out_valid), 32'd0);
    check("rst_pending_dat", 32'(ec_msg), 32'd0);

    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle_vld", 32'(out_valid), 32'd0);
    check("post_rst_idle_dat", 32'(ec_msg), 32'd0);
    @(negedge clk);
    check("post_rst_idle2_vld", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
